// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed 7-segment scan controller. Latches a frame
//                of BCD digits plus decimal points, scans a one-cold anode
//                across the digits with a blanking gap at the start of every
//                slot, and commits new frames only at the frame boundary.
//                Optional macro SEG_BLINK_EN adds per-digit blinking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_DIV    = 250
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic                    pending,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              cathode
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic                    slot_end;
   logic                    wrap;

   logic [4*NUM_DIGITS-1:0] disp_code;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic [4*NUM_DIGITS-1:0] pend_code;
   logic [NUM_DIGITS-1:0]   pend_dp;

   logic [3:0]              cur_code;
   logic                    cur_dp;
   logic [6:0]              seg;
   logic                    digit_off;
   logic [NUM_DIGITS-1:0]   anode_next;

   assign slot_end    = (presc == PRESC_LAST);
   assign wrap        = slot_end && (idx == IDX_LAST);
   assign frame_start = wrap;

   // Slot prescaler and digit index; index advances once per full slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (slot_end) begin
         presc <= '0;
         idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Frame buffering: loads park in the pending bank and are promoted only on
   // the wrap cycle; a load on the wrap cycle itself bypasses straight to display.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_code <= {NUM_DIGITS{4'hF}};
         disp_dp   <= '0;
         pend_code <= {NUM_DIGITS{4'hF}};
         pend_dp   <= '0;
         pending   <= 1'b0;
      end else if (wrap && load) begin
         disp_code <= digits_in;
         disp_dp   <= dp_in;
         pending   <= 1'b0;
      end else if (wrap && pending) begin
         disp_code <= pend_code;
         disp_dp   <= pend_dp;
         pending   <= 1'b0;
      end else if (load) begin
         pend_code <= digits_in;
         pend_dp   <= dp_in;
         pending   <= 1'b1;
      end
   end

   assign cur_code = disp_code[{idx, 2'b00} +: 4];
   assign cur_dp   = disp_dp[idx];

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] frame_cnt;
   logic          blink_on;

   // Blink phase toggles after every BLINK_DIV completed frames; starts visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (wrap) begin
         if (frame_cnt == BLINK_LAST) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Mask is taken live so blinking digits can be chosen without a reload.
   assign digit_off = ~blink_on & blink_mask[idx];
`else
   assign digit_off = 1'b0;
`endif

   // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
   always_comb begin
      seg = 7'h7F;
      case (cur_code)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
   end

   // Anode select: all off during the blanking window, else enable current digit.
   always_comb begin
      anode_next = '1;
      if (presc >= BLANK_LIM) begin
         anode_next[idx] = 1'b0;
      end
   end

   // Registered pin drivers so the pads see glitch-free levels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         anode   <= '1;
         cathode <= 8'hFF;
      end else begin
         anode   <= anode_next;
         cathode <= digit_off ? 8'hFF : {~cur_dp, seg};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver (4 digits, 4-cycle
//                slots, 1 blank cycle). Expected slot outputs are queued when
//                stimulus is applied and compared as each frame is scanned.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic          load;
   logic          pending;
   logic          frame_start;
   logic [3:0]    anode;
   logic [7:0]    cathode;
`ifdef SEG_BLINK_EN
   logic [3:0]    blink_mask;
`endif

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] cat;
      logic       fs;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] obs_an  [16];
   logic [7:0] obs_cat [16];
   logic       obs_fs  [16];
   bit         sync_ok;
   int         tests = 0;
   int         fails = 0;

   seg_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1),
      .BLINK_DIV    (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .load        (load),
`ifdef SEG_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .pending     (pending),
      .frame_start (frame_start),
      .anode       (anode),
      .cathode     (cathode)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Queue the 16 expected slot samples of one frame (digit 0 first).
   function automatic void push_frame(input logic [7:0] c0, input logic [7:0] c1,
                                      input logic [7:0] c2, input logic [7:0] c3);
      logic [7:0] cats [4];
      exp_t e;
      cats[0] = c0; cats[1] = c1; cats[2] = c2; cats[3] = c3;
      for (int j = 0; j < 16; j++) begin
         e.an  = ((j % 4) == 0) ? 4'hF : ~(4'b0001 << (j / 4));
         e.cat = cats[j / 4];
         e.fs  = (j == 14);
         sb.push_back(e);
      end
   endfunction

   // Sample one whole frame. If not synced, first wait for the wrap cycle.
   task automatic collect_frame(input bit synced);
      int n;
      sync_ok = 1'b1;
      if (!synced) begin
         n = 0;
         while (frame_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
         end
         if (frame_start !== 1'b1) begin
            sync_ok = 1'b0;
            return;
         end
         @(negedge clk);
      end
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         obs_an[j]  = anode;
         obs_cat[j] = cathode;
         obs_fs[j]  = frame_start;
      end
   endtask

   task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
      digits_in = d;
      dp_in     = p;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      #12;
      tests++;
      if (anode !== 4'hF || cathode !== 8'hFF || pending !== 1'b0 || frame_start !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: an=%h cat=%h pend=%b fs=%b, want F FF 0 0",
                  anode, cathode, pending, frame_start);
      end
      @(negedge clk);
      reset_n = 1'b1;
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int f = 0; f < 2; f++) begin
         collect_frame(1'b1);
         for (int j = 0; j < 16; j++) begin
            e = sb.pop_front();
            tests++;
            if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
               fails++;
               $display("FAIL reset_scan f%0d slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                        f, j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
            end
         end
      end
   endtask

   task automatic test_load_mid_frame();
      exp_t e;
      int   n;
      repeat (5) @(negedge clk);
      pulse_load(16'h1234, 4'b0100);
      push_frame(8'h99, 8'hB0, 8'h24, 8'hF9);
      n = 0;
      while (frame_start !== 1'b1 && n < 32) begin
         tests++;
         if (pending !== 1'b1 || cathode !== 8'hFF) begin
            fails++;
            $display("FAIL load_hold: pend=%b cat=%h, want 1 FF", pending, cathode);
         end
         @(negedge clk);
         n++;
      end
      collect_frame(1'b0);
      tests++;
      if (!sync_ok) begin
         fails++;
         $display("FAIL load_sync: frame_start=%b, want 1 within bound", frame_start);
      end
      for (int j = 0; j < 16; j++) begin
         e = sb.pop_front();
         tests++;
         if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
            fails++;
            $display("FAIL load_frame slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                     j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
         end
      end
      tests++;
      if (pending !== 1'b0) begin
         fails++;
         $display("FAIL load_commit: pend=%b, want 0", pending);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      repeat (2) @(negedge clk);
      pulse_load(16'h1111, 4'b0000);
      repeat (3) @(negedge clk);
      pulse_load(16'h9999, 4'b0000);
      tests++;
      if (pending !== 1'b1) begin
         fails++;
         $display("FAIL b2b_pending: pend=%b, want 1", pending);
      end
      push_frame(8'h90, 8'h90, 8'h90, 8'h90);
      push_frame(8'h90, 8'h90, 8'h90, 8'h90);
      for (int f = 0; f < 2; f++) begin
         collect_frame(f != 0);
         for (int j = 0; j < 16; j++) begin
            e = sb.pop_front();
            tests++;
            if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
               fails++;
               $display("FAIL b2b_frame f%0d slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                        f, j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
            end
         end
         tests++;
         if (pending !== 1'b0) begin
            fails++;
            $display("FAIL b2b_commit f%0d: pend=%b, want 0", f, pending);
         end
      end
   endtask

   task automatic test_wrap_load();
      exp_t e;
      int   n;
      n = 0;
      while (frame_start !== 1'b1 && n < 32) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (frame_start !== 1'b1) begin
         fails++;
         $display("FAIL wrap_sync: frame_start=%b, want 1", frame_start);
      end
      pulse_load(16'h5678, 4'b0000);
      tests++;
      if (pending !== 1'b0) begin
         fails++;
         $display("FAIL wrap_pending: pend=%b, want 0", pending);
      end
      push_frame(8'h80, 8'hF8, 8'h82, 8'h92);
      collect_frame(1'b1);
      for (int j = 0; j < 16; j++) begin
         e = sb.pop_front();
         tests++;
         if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
            fails++;
            $display("FAIL wrap_frame slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                     j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
         end
      end
   endtask

   task automatic test_blank_dp();
      exp_t e;
      repeat (3) @(negedge clk);
      pulse_load(16'hFC0C, 4'b1001);
      push_frame(8'h7F, 8'hC0, 8'hFF, 8'h7F);
      collect_frame(1'b0);
      tests++;
      if (!sync_ok) begin
         fails++;
         $display("FAIL blank_sync: frame_start=%b, want 1 within bound", frame_start);
      end
      for (int j = 0; j < 16; j++) begin
         e = sb.pop_front();
         tests++;
         if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
            fails++;
            $display("FAIL blank_frame slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                     j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
         end
      end
   endtask

   task automatic test_reset_mid_slot();
      exp_t e;
      @(negedge clk);
      pulse_load(16'h3333, 4'b0000);
      tests++;
      if (anode !== 4'hE || cathode !== 8'h7F || pending !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset: an=%h cat=%h pend=%b, want E 7F 1", anode, cathode, pending);
      end
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if (anode !== 4'hF || cathode !== 8'hFF || pending !== 1'b0 || frame_start !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: an=%h cat=%h pend=%b fs=%b, want F FF 0 0",
                  anode, cathode, pending, frame_start);
      end
      @(negedge clk);
      reset_n = 1'b1;
      push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      collect_frame(1'b1);
      for (int j = 0; j < 16; j++) begin
         e = sb.pop_front();
         tests++;
         if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
            fails++;
            $display("FAIL restart_frame slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                     j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
         end
      end
   endtask

`ifdef SEG_BLINK_EN
   task automatic test_blink();
      exp_t e;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n    = 1'b1;
      blink_mask = 4'b0001;
      pulse_load(16'h8888, 4'b0000);
      push_frame(8'h80, 8'h80, 8'h80, 8'h80);
      push_frame(8'hFF, 8'h80, 8'h80, 8'h80);
      push_frame(8'hFF, 8'h80, 8'h80, 8'h80);
      push_frame(8'h80, 8'h80, 8'h80, 8'h80);
      push_frame(8'h80, 8'h80, 8'h80, 8'h80);
      for (int f = 0; f < 5; f++) begin
         collect_frame(f != 0);
         for (int j = 0; j < 16; j++) begin
            e = sb.pop_front();
            tests++;
            if ({obs_an[j], obs_cat[j], obs_fs[j]} !== {e.an, e.cat, e.fs}) begin
               fails++;
               $display("FAIL blink_frame f%0d slot %0d: an=%h cat=%h fs=%b, want an=%h cat=%h fs=%b",
                        f, j, obs_an[j], obs_cat[j], obs_fs[j], e.an, e.cat, e.fs);
            end
         end
      end
      blink_mask = 4'b0000;
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
`ifdef SEG_BLINK_EN
      blink_mask = 4'b0000;
`endif
      test_reset();
      test_load_mid_frame();
      test_back_to_back();
      test_wrap_load();
      test_blank_dp();
      test_reset_mid_slot();
`ifdef SEG_BLINK_EN
      test_blink();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
